// File: rtl/ex_muldiv.sv
// Iterative multiply/divide unit for the EX stage: shift-add multiplier and
// restoring divider sharing one datapath, producing a {HI,LO} result.
module ex_muldiv #(
   parameter int WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start_i,
   input  logic [2:0]           op_i,
   input  logic [WIDTH-1:0]     opdata1_i,
   input  logic [WIDTH-1:0]     opdata2_i,
   input  logic                 annul_i,
   output logic [2*WIDTH-1:0]   result_o,
   output logic                 ready_o,
   output logic                 busy_o,
   output logic                 stallreq_o
);

   localparam int CNT_W = $clog2(WIDTH) + 1;

   localparam logic [2:0] OP_MULT  = 3'b001;
   localparam logic [2:0] OP_MULTU = 3'b010;
   localparam logic [2:0] OP_DIV   = 3'b011;
   localparam logic [2:0] OP_DIVU  = 3'b100;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DIV  = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t               state;
   logic [CNT_W-1:0]     cnt;
   logic [WIDTH:0]       acc;
   logic [WIDTH-1:0]     lo;
   logic [WIDTH-1:0]     opb;
   logic                 neg_q;
   logic                 neg_r;
   logic                 is_div;
   logic                 dbz;
   logic [2*WIDTH-1:0]   result_q;

   logic                 op_valid;
   logic                 op_signed;
   logic                 op_is_div;
   logic                 accept;
   logic                 a_neg;
   logic                 b_neg;
   logic [WIDTH-1:0]     a_abs;
   logic [WIDTH-1:0]     b_abs;
   logic                 last_step;

   logic [WIDTH:0]       mul_add;
   logic [WIDTH:0]       div_shift;
   logic [WIDTH+1:0]     div_diff;
   logic [2*WIDTH-1:0]   product;
   logic [WIDTH-1:0]     rem_fix;
   logic [WIDTH-1:0]     quot_fix;
   logic [2*WIDTH-1:0]   corrected;

   // Operand decode and absolute values taken at start acceptance
   always_comb begin
      op_valid  = (op_i == OP_MULT) || (op_i == OP_MULTU) ||
                  (op_i == OP_DIV)  || (op_i == OP_DIVU);
      op_signed = (op_i == OP_MULT) || (op_i == OP_DIV);
      op_is_div = (op_i == OP_DIV)  || (op_i == OP_DIVU);
      accept    = (state == IDLE) && start_i && op_valid && !annul_i;
      a_neg     = op_signed && opdata1_i[WIDTH-1];
      b_neg     = op_signed && opdata2_i[WIDTH-1];
      a_abs     = a_neg ? -opdata1_i : opdata1_i;
      b_abs     = b_neg ? -opdata2_i : opdata2_i;
      last_step = (cnt == CNT_W'(WIDTH - 1));
   end

   // One iteration of each algorithm plus the final sign correction
   always_comb begin
      mul_add   = lo[0] ? (acc + {1'b0, opb}) : acc;
      div_shift = {acc[WIDTH-1:0], lo[WIDTH-1]};
      div_diff  = {1'b0, div_shift} - {2'b00, opb};
      product   = {acc[WIDTH-1:0], lo};
      rem_fix   = neg_r ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
      quot_fix  = neg_q ? -lo : lo;
      if (dbz) begin
         corrected = {lo, {WIDTH{1'b1}}};
      end else if (is_div) begin
         corrected = {rem_fix, quot_fix};
      end else begin
         corrected = neg_q ? -product : product;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         cnt      <= '0;
         acc      <= '0;
         lo       <= '0;
         opb      <= '0;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
         is_div   <= 1'b0;
         dbz      <= 1'b0;
         result_q <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  cnt    <= '0;
                  acc    <= '0;
                  neg_q  <= a_neg ^ b_neg;
                  neg_r  <= a_neg;
                  is_div <= op_is_div;
                  if (op_is_div && (opdata2_i == '0)) begin
                     // Divide by zero skips iteration and returns the raw dividend
                     dbz   <= 1'b1;
                     lo    <= opdata1_i;
                     opb   <= '0;
                     state <= DONE;
                  end else if (op_is_div) begin
                     dbz   <= 1'b0;
                     lo    <= a_abs;
                     opb   <= b_abs;
                     state <= DIV;
                  end else begin
                     dbz   <= 1'b0;
                     lo    <= b_abs;
                     opb   <= a_abs;
                     state <= MUL;
                  end
               end
            end
            MUL: begin
               if (annul_i) begin
                  state <= IDLE;
               end else begin
                  acc <= {1'b0, mul_add[WIDTH:1]};
                  lo  <= {mul_add[0], lo[WIDTH-1:1]};
                  cnt <= cnt + CNT_W'(1);
                  if (last_step) state <= DONE;
               end
            end
            DIV: begin
               if (annul_i) begin
                  state <= IDLE;
               end else begin
                  if (!div_diff[WIDTH+1]) begin
                     acc <= div_diff[WIDTH:0];
                     lo  <= {lo[WIDTH-2:0], 1'b1};
                  end else begin
                     acc <= div_shift;
                     lo  <= {lo[WIDTH-2:0], 1'b0};
                  end
                  cnt <= cnt + CNT_W'(1);
                  if (last_step) state <= DONE;
               end
            end
            DONE: begin
               if (!annul_i) result_q <= corrected;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // The corrected result is presented in the DONE cycle itself so EX can
   // capture it while the stall is already released
   always_comb begin
      busy_o     = (state == MUL) || (state == DIV);
      ready_o    = (state == DONE) && !annul_i;
      stallreq_o = accept || (busy_o && !annul_i);
      result_o   = ready_o ? corrected : result_q;
   end

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed self-checking bench for ex_muldiv at WIDTH=32 with hand-computed
// products, quotients, remainders and latencies.
module tb_ex_muldiv;

   localparam int W = 32;

   logic            clk;
   logic            rst;
   logic            start_i;
   logic [2:0]      op_i;
   logic [W-1:0]    opdata1_i;
   logic [W-1:0]    opdata2_i;
   logic            annul_i;
   logic [2*W-1:0]  result_o;
   logic            ready_o;
   logic            busy_o;
   logic            stallreq_o;

   int errors;
   int checks;

   ex_muldiv #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst        (rst),
      .start_i    (start_i),
      .op_i       (op_i),
      .opdata1_i  (opdata1_i),
      .opdata2_i  (opdata2_i),
      .annul_i    (annul_i),
      .result_o   (result_o),
      .ready_o    (ready_o),
      .busy_o     (busy_o),
      .stallreq_o (stallreq_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports mismatches
   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got=0x%016h expected=0x%016h", tag, got, exp);
      end
   endtask

   // Issues one operation in the cycle after the next rising edge, then
   // watches for ready_o with a bounded wait and checks latency and result
   task automatic applyStimulus(input string tag, input logic [2:0] op, input logic [31:0] a,
                                input logic [31:0] b, input logic [63:0] exp_res, input int exp_lat);
      int lat;
      logic stall_ok;
      @(posedge clk); #1;
      start_i = 1'b1; op_i = op; opdata1_i = a; opdata2_i = b;
      @(negedge clk);
      checkOutput({tag, "_stall_start"}, 64'(stallreq_o), 64'd1);
      @(posedge clk); #1;
      start_i = 1'b0; op_i = 3'b000;
      lat = 0;
      stall_ok = 1'b1;
      for (int i = 1; i <= 60; i++) begin
         @(negedge clk);
         if (ready_o) begin
            lat = i;
            break;
         end
         if (!stallreq_o || !busy_o) stall_ok = 1'b0;
      end
      checkOutput({tag, "_latency"}, 64'(lat), 64'(exp_lat));
      checkOutput({tag, "_stall_busy"}, 64'(stall_ok), 64'd1);
      checkOutput({tag, "_result"}, result_o, exp_res);
      checkOutput({tag, "_stall_done"}, 64'(stallreq_o), 64'd0);
      @(negedge clk);
      checkOutput({tag, "_ready_pulse"}, 64'(ready_o), 64'd0);
      checkOutput({tag, "_result_hold"}, result_o, exp_res);
   endtask

   initial begin
      logic saw_ready;
      errors = 0;
      checks = 0;
      rst = 1'b0;
      start_i = 1'b0;
      op_i = 3'b000;
      opdata1_i = '0;
      opdata2_i = '0;
      annul_i = 1'b0;

      #12;
      checkOutput("reset_result", result_o, 64'd0);
      checkOutput("reset_ready", 64'(ready_o), 64'd0);
      checkOutput("reset_busy", 64'(busy_o), 64'd0);
      checkOutput("reset_stall", 64'(stallreq_o), 64'd0);
      @(negedge clk);
      rst = 1'b1;

      applyStimulus("mult_neg3x7", 3'b001, 32'hFFFF_FFFD, 32'd7, 64'hFFFF_FFFF_FFFF_FFEB, 33);
      applyStimulus("multu_max", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 33);
      applyStimulus("mult_minsq", 3'b001, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 33);
      applyStimulus("divu_100_7", 3'b100, 32'd100, 32'd7, 64'h0000_0002_0000_000E, 33);
      applyStimulus("div_m7_2", 3'b011, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, 33);
      applyStimulus("div_7_m2", 3'b011, 32'd7, 32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD, 33);
      applyStimulus("div_5_0", 3'b011, 32'd5, 32'd0, 64'h0000_0005_FFFF_FFFF, 1);
      applyStimulus("div_m5_0", 3'b011, 32'hFFFF_FFFB, 32'd0, 64'hFFFF_FFFB_FFFF_FFFF, 1);
      applyStimulus("div_ovf", 3'b011, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 33);

      // Annul mid-divide: stall drops at once, no ready, result kept
      @(posedge clk); #1;
      start_i = 1'b1; op_i = 3'b100; opdata1_i = 32'd1000; opdata2_i = 32'd3;
      @(posedge clk); #1;
      start_i = 1'b0; op_i = 3'b000;
      saw_ready = 1'b0;
      for (int i = 1; i <= 9; i++) begin
         @(negedge clk);
         saw_ready = saw_ready | ready_o;
         @(posedge clk);
      end
      #1 annul_i = 1'b1;
      @(negedge clk);
      checkOutput("annul_stall", 64'(stallreq_o), 64'd0);
      checkOutput("annul_busy_same", 64'(busy_o), 64'd1);
      @(posedge clk); #1;
      annul_i = 1'b0;
      @(negedge clk);
      checkOutput("annul_busy_next", 64'(busy_o), 64'd0);
      saw_ready = saw_ready | ready_o;
      checkOutput("annul_no_ready", 64'(saw_ready), 64'd0);
      checkOutput("annul_result_kept", result_o, 64'h0000_0000_8000_0000);
      applyStimulus("mult_2x3", 3'b001, 32'd2, 32'd3, 64'd6, 33);

      // Annul together with start in IDLE, and an invalid op code
      @(posedge clk); #1;
      start_i = 1'b1; op_i = 3'b001; opdata1_i = 32'd9; opdata2_i = 32'd9; annul_i = 1'b1;
      @(negedge clk);
      checkOutput("idle_annul_stall", 64'(stallreq_o), 64'd0);
      @(posedge clk); #1;
      annul_i = 1'b0; op_i = 3'b111;
      @(negedge clk);
      checkOutput("idle_annul_busy", 64'(busy_o), 64'd0);
      checkOutput("invalid_stall", 64'(stallreq_o), 64'd0);
      @(posedge clk); #1;
      start_i = 1'b0; op_i = 3'b000;
      @(negedge clk);
      checkOutput("invalid_busy", 64'(busy_o), 64'd0);

      // Annul in DONE after divide by zero: ready suppressed, result not updated
      @(posedge clk); #1;
      start_i = 1'b1; op_i = 3'b011; opdata1_i = 32'd5; opdata2_i = 32'd0;
      @(posedge clk); #1;
      start_i = 1'b0; op_i = 3'b000; annul_i = 1'b1;
      @(negedge clk);
      checkOutput("done_annul_ready", 64'(ready_o), 64'd0);
      checkOutput("done_annul_result", result_o, 64'd6);
      @(posedge clk); #1;
      annul_i = 1'b0;
      @(negedge clk);
      checkOutput("done_annul_after", result_o, 64'd6);
      checkOutput("done_annul_busy", 64'(busy_o), 64'd0);

      // Asynchronous reset in the middle of a multiply
      @(posedge clk); #1;
      start_i = 1'b1; op_i = 3'b010; opdata1_i = 32'd12; opdata2_i = 32'd12;
      @(posedge clk); #1;
      start_i = 1'b0; op_i = 3'b000;
      repeat (5) @(posedge clk);
      @(negedge clk);
      checkOutput("prereset_busy", 64'(busy_o), 64'd1);
      #2 rst = 1'b0;
      #1;
      checkOutput("async_rst_busy", 64'(busy_o), 64'd0);
      checkOutput("async_rst_stall", 64'(stallreq_o), 64'd0);
      checkOutput("async_rst_ready", 64'(ready_o), 64'd0);
      checkOutput("async_rst_result", result_o, 64'd0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      applyStimulus("post_rst_multu", 3'b010, 32'd12, 32'd12, 64'd144, 33);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
